// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen
//  Description : Streaming line buffer and KERNEL_W x KERNEL_W window
//                generator. Accepts a raster-order pixel stream, one pixel
//                per valid cycle, keeps the previous KERNEL_W-1 lines in
//                cascaded line buffers and presents a registered window
//                [row][col] with a valid strobe one cycle after each
//                accepted pixel.
//
//  Parameters  : DATA_W   - pixel width in bits
//                KERNEL_W - window side (>= 2)
//                IMG_W    - pixels per image line (>= KERNEL_W)
//
//  Ports       : clk_i              - clock, rising edge
//                srst_i             - synchronous active-high reset
//                pixel_i            - incoming pixel, raster order
//                pixel_valid_i      - pixel_i accepted this cycle
//                sof_i              - start of frame (WINDOW_GEN_SOF_EN only)
//                pixel_data_o       - window, indexed [row][col]; row 0 is
//                                     the oldest line, col 0 the leftmost
//                pixel_data_valid_o - pixel_data_o is a complete window
//
//  Options     : WINDOW_GEN_SOF_EN - adds sof_i; a pixel accepted with
//                sof_i = 1 restarts the frame at (0,0) and re-enters FILL.
//
//  Revision    : 1.0 - initial release
// ============================================================================

module window_gen #(
    parameter int DATA_W   = 8,
    parameter int KERNEL_W = 3,
    parameter int IMG_W    = 512
) (
    input  logic                                         clk_i,
    input  logic                                         srst_i,
    input  logic [DATA_W-1:0]                            pixel_i,
    input  logic                                         pixel_valid_i,
`ifdef WINDOW_GEN_SOF_EN
    input  logic                                         sof_i,
`endif
    output logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0] pixel_data_o,
    output logic                                         pixel_data_valid_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_LC_W  = $clog2(KERNEL_W);
    localparam int c_NBUF  = KERNEL_W - 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST        = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_COL_FIRST_VALID = c_COL_W'(KERNEL_W - 1);
    localparam logic [c_LC_W-1:0]  c_LC_SAT          = c_LC_W'(KERNEL_W - 1);
    localparam logic [c_LC_W-1:0]  c_LC_LAST_FILL    = c_LC_W'(KERNEL_W - 2);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_cur;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Counters and control
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0] r_col;
    logic [c_COL_W-1:0] w_col_cur;
    logic [c_COL_W-1:0] w_col_next;
    logic [c_LC_W-1:0]  r_line_cnt;
    logic [c_LC_W-1:0]  w_line_cur;
    logic [c_LC_W-1:0]  w_line_next;

    logic w_accept;
    logic w_sof;
    logic w_col_wrap;
    logic w_fill_done;
    logic w_win_valid;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_lbuf [c_NBUF][IMG_W];
    logic [DATA_W-1:0] w_lbuf_rd [c_NBUF];

    logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0] r_win;
    logic                                         r_valid;

    // A pixel presented together with srst_i is dropped, so buffer writes
    // (which are not under reset) must be gated here as well.
    assign w_accept = pixel_valid_i & ~srst_i;

`ifdef WINDOW_GEN_SOF_EN
    assign w_sof = sof_i;
`else
    assign w_sof = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Effective position of the current pixel. A start-of-frame pixel is
    // handled as if the counters and FSM had already been restarted, so it
    // lands at column 0 of line 0 and is processed in FILL.
    // ------------------------------------------------------------------------
    always_comb begin
        w_col_cur   = r_col;
        w_line_cur  = r_line_cnt;
        w_state_cur = r_state;
        if (w_sof) begin
            w_col_cur   = '0;
            w_line_cur  = '0;
            w_state_cur = ST_FILL;
        end
    end

    assign w_col_wrap  = (w_col_cur == c_COL_LAST);
    assign w_col_next  = w_col_wrap ? '0 : (w_col_cur + 1'b1);
    assign w_line_next = (w_col_wrap && (w_line_cur != c_LC_SAT))
                         ? (w_line_cur + 1'b1) : w_line_cur;
    assign w_fill_done = w_col_wrap && (w_line_cur == c_LC_LAST_FILL);

    // ------------------------------------------------------------------------
    // Column / line counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_col      <= '0;
            r_line_cnt <= '0;
        end else if (w_accept) begin
            r_col      <= w_col_next;
            r_line_cnt <= w_line_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and window-valid decode.
    // The pixel that closes the last fill line still sits in a window whose
    // top row lies above the image, so a window is only flagged valid for
    // pixels accepted while already in RUN, and never for the first
    // KERNEL_W-1 columns (those windows straddle the line wrap).
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_win_valid  = 1'b0;
        if (w_accept) begin
            w_state_next = w_state_cur;
            case (w_state_cur)
                ST_FILL: begin
                    if (w_fill_done) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_win_valid = (w_col_cur >= c_COL_FIRST_VALID);
                end
                default: begin
                    w_state_next = ST_FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers: read-before-write at the current column. Buffer k holds
    // the line k+1 above the incoming pixel; its old entry cascades into
    // buffer k+1 as it is overwritten.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < c_NBUF; k++) begin : g_lbuf_rd
        assign w_lbuf_rd[k] = r_lbuf[k][w_col_cur];
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lbuf[0][w_col_cur] <= pixel_i;
            for (int k = 1; k < c_NBUF; k++) begin
                r_lbuf[k][w_col_cur] <= w_lbuf_rd[k-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Window shift register. Every accepted pixel shifts each row one column
    // left and loads the rightmost column: bottom row from the live pixel,
    // the rows above from successively older line buffers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_win   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_win_valid;
            if (w_accept) begin
                for (int r = 0; r < KERNEL_W; r++) begin
                    for (int c = 0; c < KERNEL_W - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                end
                r_win[KERNEL_W-1][KERNEL_W-1] <= pixel_i;
                for (int k = 1; k < KERNEL_W; k++) begin
                    r_win[KERNEL_W-1-k][KERNEL_W-1] <= w_lbuf_rd[k-1];
                end
            end
        end
    end

    assign pixel_data_o       = r_win;
    assign pixel_data_valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_gen
//  Description : Scoreboard bench for window_gen (IMG_W=8, KERNEL_W=3,
//                DATA_W=8). The driver records each pixel into an image
//                history and queues the window expected one cycle later;
//                a monitor pops and compares on every valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_window_gen;

    logic       clk = 1'b0;
    logic       srst;
    logic [7:0] pix;
    logic       pv;
`ifdef WINDOW_GEN_SOF_EN
    logic       sof;
`endif
    logic [2:0][2:0][7:0] win;
    logic                 wv;

    always #5 clk = ~clk;

    window_gen #(
        .DATA_W   (8),
        .KERNEL_W (3),
        .IMG_W    (8)
    ) dut (
        .clk_i              (clk),
        .srst_i             (srst),
        .pixel_i            (pix),
        .pixel_valid_i      (pv),
`ifdef WINDOW_GEN_SOF_EN
        .sof_i              (sof),
`endif
        .pixel_data_o       (win),
        .pixel_data_valid_o (wv)
    );

    typedef struct {
        int          stamp;
        int          tag;
        logic [71:0] w;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_valid = 0;
    int   cyc     = 0;
    int   hist [0:31][0:7];
    int   m_x = 0;
    int   m_y = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Image-level model: window valid once two full lines precede the pixel
    // and it is at least two columns into its line.
    task automatic push_model(input int v);
        exp_t e;
        logic [2:0][2:0][7:0] ew;
        hist[m_y][m_x] = v;
        if (m_y >= 2 && m_x >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    ew[r][c] = 8'(hist[m_y-2+r][m_x-2+c]);
            e.stamp = cyc + 1;
            e.tag   = v;
            e.w     = ew;
            q.push_back(e);
        end
        m_x++;
        if (m_x == 8) begin
            m_x = 0;
            m_y++;
        end
    endtask

    task automatic send(input int v);
        @(negedge clk);
        pix = 8'(v);
        pv  = 1'b1;
`ifdef WINDOW_GEN_SOF_EN
        sof = 1'b0;
`endif
        push_model(v);
    endtask

`ifdef WINDOW_GEN_SOF_EN
    task automatic send_sof(input int v);
        @(negedge clk);
        pix = 8'(v);
        pv  = 1'b1;
        sof = 1'b1;
        m_x = 0;
        m_y = 0;
        push_model(v);
    endtask
`endif

    task automatic idle();
        @(negedge clk);
        pv  = 1'b0;
        pix = 8'hEE;
`ifdef WINDOW_GEN_SOF_EN
        sof = 1'b0;
`endif
    endtask

    // Reset for one cycle with a (discarded) pixel presented alongside.
    task automatic do_reset(input bit chk);
        @(negedge clk);
        srst = 1'b1;
        pv   = 1'b1;
        pix  = 8'd99;
        @(posedge clk);
        #1;
        if (chk) begin
            check("rst_mid_data", win, 72'd0);
            check("rst_mid_valid", wv, 1'b0);
        end
        @(negedge clk);
        srst = 1'b0;
        pv   = 1'b0;
        m_x  = 0;
        m_y  = 0;
    endtask

    // Hand-computed spot checks for a frame with P(y,x)=8y+x.
    task automatic hand_checks(input int p);
        logic [2:0][2:0][7:0] h;
        if (p == 18 || p == 24 || p == 25 || p == 26) begin
            @(posedge clk);
            #1;
            if (p == 18) begin
                check("first_valid", wv, 1'b1);
                check("first_00", win[0][0], 8'd0);
                check("first_11", win[1][1], 8'd9);
                check("first_22", win[2][2], 8'd18);
                check("first_02", win[0][2], 8'd2);
                check("first_20", win[2][0], 8'd16);
            end else if (p == 26) begin
                h[0] = {8'd10, 8'd9, 8'd8};
                h[1] = {8'd18, 8'd17, 8'd16};
                h[2] = {8'd26, 8'd25, 8'd24};
                check("wrap_valid", wv, 1'b1);
                check("wrap_win", win, h);
            end else begin
                check("wrap_invalid", wv, 1'b0);
            end
        end
    endtask

    // Monitor / scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (wv) begin
            n_valid++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: actual window %h required no valid", win);
            end else begin
                e = q.pop_front();
                check("win_timing", cyc, e.stamp);
                check("win_data", win, e.w);
            end
        end
    end

    initial begin
        int n0;
        srst = 1'b1;
        pv   = 1'b0;
        pix  = 8'd0;
`ifdef WINDOW_GEN_SOF_EN
        sof  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", win, 72'd0);
        check("reset_valid", wv, 1'b0);
        @(negedge clk);
        srst = 1'b0;

        // Continuous frame
        n0 = n_valid;
        for (int p = 0; p < 32; p++) begin
            send(p);
            hand_checks(p);
        end
        idle(); idle();
        check("count_cont", n_valid - n0, 12);

        // Same frame with idle cycles between pixels
        do_reset(1'b0);
        n0 = n_valid;
        for (int p = 0; p < 32; p++) begin
            send(p);
            hand_checks(p);
            idle();
        end
        idle();
        check("count_gaps", n_valid - n0, 12);

        // Reset mid-frame after pixel 20, then restart
        do_reset(1'b0);
        for (int p = 0; p <= 20; p++) begin
            send(p);
            hand_checks(p);
        end
        do_reset(1'b1);
        n0 = n_valid;
        for (int p = 0; p < 32; p++) begin
            send(p);
            hand_checks(p);
        end
        idle(); idle();
        check("count_restart", n_valid - n0, 12);

        // Second frame directly after, values 64+8y+x
        n0 = n_valid;
`ifdef WINDOW_GEN_SOF_EN
        send_sof(64);
`else
        send(64);
`endif
        for (int p = 1; p < 32; p++) begin
            send(64 + p);
            if (p == 2) begin
                @(posedge clk);
                #1;
`ifdef WINDOW_GEN_SOF_EN
                check("f2_px2_valid", wv, 1'b0);
`else
                check("f2_px2_valid", wv, 1'b1);
                check("f2_px2_00", win[0][0], 8'd16);
                check("f2_px2_22", win[2][2], 8'd66);
`endif
            end
`ifdef WINDOW_GEN_SOF_EN
            if (p == 18) begin
                @(posedge clk);
                #1;
                check("f2_px18_valid", wv, 1'b1);
                check("f2_px18_00", win[0][0], 8'd64);
                check("f2_px18_22", win[2][2], 8'd82);
            end
`endif
        end
        idle(); idle();
`ifdef WINDOW_GEN_SOF_EN
        check("count_frame2", n_valid - n0, 12);
`else
        check("count_frame2", n_valid - n0, 24);
`endif
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
